// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed byte stream and
// writes it as little-endian 32-bit words, holding the CPU until done.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_len;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;

    logic              w_xfer;
    logic              w_start_ok;
    logic [15:0]       w_len_full;
    logic              w_len_bad;
    logic [ADDR_W:0]   w_count_inc;
    logic              w_last;

    assign w_xfer      = byte_valid & byte_ready;
    assign w_start_ok  = start & ((r_state == S_IDLE) |
                                  (r_state == S_DONE) |
                                  (r_state == S_ERR));
    assign w_len_full  = {byte_data, r_len[7:0]};
    assign w_len_bad   = (w_len_full == 16'd0) |
                         ({16'd0, w_len_full} > DEPTH);
    assign w_count_inc = r_count + (ADDR_W+1)'(1);
    assign w_last      = (32'(w_count_inc) == {16'd0, r_len});

    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign words_loaded = r_count;

    // Per-state output decode; everything is a function of the state register
    always_comb begin
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        unique case (r_state)
            S_LEN_LO: byte_ready = 1'b1;
            S_LEN_HI: byte_ready = 1'b1;
            S_DATA:   byte_ready = 1'b1;
            S_WRITE:  imem_we    = 1'b1;
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERR:    error      = 1'b1;
            default: ;
        endcase
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) w_next = w_len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (w_xfer && r_lane == 2'd3) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_next = w_last ? S_DONE : S_DATA;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register and datapath: length capture, byte lanes, address, count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_len   <= 16'd0;
            r_lane  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_count <= '0;
                r_len   <= 16'd0;
            end
            case (r_state)
                S_LEN_LO: begin
                    if (w_xfer) r_len[7:0] <= byte_data;
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= byte_data;
                        r_addr      <= '0;
                        r_lane      <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_wdata[8*r_lane +: 8] <= byte_data;
                        r_lane                 <= r_lane + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_count <= w_count_inc;
                    r_lane  <= 2'd0;
                    if (!w_last) r_addr <= r_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized images against a
// word-list model, with a wide (ADDR_W=8) and a tiny (ADDR_W=2) instance.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       valid;
    logic [7:0] data;
    bit         sel;

    logic       st8, v8, st2, v2;
    logic       rdy8, we8, hold8, done8, err8;
    logic [7:0] addr8;
    logic [31:0] wd8;
    logic [8:0] wl8;
    logic       rdy2, we2, hold2, done2, err2;
    logic [1:0] addr2;
    logic [31:0] wd2;
    logic [2:0] wl2;
    logic       w_rdy, w_done, w_err;

    assign st8 = sel ? 1'b0 : start;
    assign v8  = sel ? 1'b0 : valid;
    assign st2 = sel ? start : 1'b0;
    assign v2  = sel ? valid : 1'b0;
    assign w_rdy  = sel ? rdy2 : rdy8;
    assign w_done = sel ? done2 : done8;
    assign w_err  = sel ? err2 : err8;

    imem_loader #(.ADDR_W(8)) u8 (
        .clk(clk), .reset(rst), .start(st8), .byte_valid(v8),
        .byte_data(data), .byte_ready(rdy8), .imem_we(we8),
        .imem_addr(addr8), .imem_wdata(wd8), .cpu_hold(hold8),
        .done(done8), .error(err8), .words_loaded(wl8)
    );

    imem_loader #(.ADDR_W(2)) u2 (
        .clk(clk), .reset(rst), .start(st2), .byte_valid(v2),
        .byte_data(data), .byte_ready(rdy2), .imem_we(we2),
        .imem_addr(addr2), .imem_wdata(wd2), .cpu_hold(hold2),
        .done(done2), .error(err2), .words_loaded(wl2)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem8 [256];
    logic [31:0] mem2 [4];
    int nw8, nw2, cyc, last_we8, first_done8, inv;
    bit pd8;
    logic [31:0] img [$];

    // Memory-write monitor and hold/done consistency watch
    always @(negedge clk) begin
        cyc++;
        if (we8) begin
            mem8[addr8] = wd8;
            nw8++;
            last_we8 = cyc;
        end
        if (we2) begin
            mem2[addr2] = wd2;
            nw2++;
        end
        if (done8 && !pd8) first_done8 = cyc;
        pd8 = done8;
        if (hold8 == done8 || hold2 == done2) inv++;
        if ((done8 && err8) || (done2 && err2)) inv++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        for (int i = 0; i < 256; i++) mem8[i] = 'x;
        for (int i = 0; i < 4; i++) mem2[i] = 'x;
        nw8 = 0;
        nw2 = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gaps, input bit sp);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                valid = 1'b0;
                data  = 8'($urandom);
                start = sp ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        valid = 1'b1;
        data  = b;
        n = 0;
        while (!w_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%02h got_ready=0 exp=1", b);
        end
        @(negedge clk);
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic send_image(input logic [15:0] len, input bit gaps,
                              input bit sp);
        logic [31:0] w;
        send(len[7:0], gaps, sp);
        send(len[15:8], gaps, sp);
        foreach (img[i]) begin
            w = img[i];
            for (int k = 0; k < 4; k++) send(w[8*k +: 8], gaps, sp);
        end
    endtask

    task automatic wait_end(output bit to);
        int n = 0;
        while (!(w_done || w_err) && n < 200) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 200);
        @(negedge clk);
    endtask

    task automatic rand_img(input int n);
        img = {};
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rdy8 !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", rdy8); end
        checks++; if (we8 !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", we8); end
        checks++; if (addr8 !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", addr8); end
        checks++; if (wd8 !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%08h exp=0", wd8); end
        checks++; if (hold8 !== 1'b1) begin failures++; $display("FAIL reset_hold got=%0b exp=1", hold8); end
        checks++; if (done8 !== 1'b0 || err8 !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%0b%0b exp=00", done8, err8); end
        checks++; if (wl8 !== 9'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", wl8); end
        checks++; if (hold2 !== 1'b1 || rdy2 !== 1'b0 || we2 !== 1'b0) begin failures++; $display("FAIL reset_small got=%0b%0b%0b exp=100", hold2, rdy2, we2); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rdy8 !== 1'b0 || hold8 !== 1'b1) begin failures++; $display("FAIL idle_outputs got=%0b%0b exp=01", rdy8, hold8); end
    endtask

    task automatic test_basic();
        bit to;
        sel = 1'b0;
        clear_mon();
        img = {32'h0000_0013, 32'h0010_0093};
        pulse_start();
        send_image(16'd2, 1'b0, 1'b0);
        wait_end(to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
        checks++; if (nw8 !== 2) begin failures++; $display("FAIL basic_nwrites got=%0d exp=2", nw8); end
        checks++; if (mem8[0] !== img[0]) begin failures++; $display("FAIL basic_w0 got=%08h exp=%08h", mem8[0], img[0]); end
        checks++; if (mem8[1] !== img[1]) begin failures++; $display("FAIL basic_w1 got=%08h exp=%08h", mem8[1], img[1]); end
        checks++; if (done8 !== 1'b1 || hold8 !== 1'b0) begin failures++; $display("FAIL basic_done_hold got=%0b%0b exp=10", done8, hold8); end
        checks++; if (wl8 !== 9'd2) begin failures++; $display("FAIL basic_words got=%0d exp=2", wl8); end
        checks++; if (first_done8 - last_we8 !== 1) begin failures++; $display("FAIL basic_done_latency got=%0d exp=1", first_done8 - last_we8); end
    endtask

    task automatic test_len_err();
        bit to;
        sel = 1'b0;
        clear_mon();
        img = {};
        pulse_start();
        send_image(16'd0, 1'b0, 1'b0);
        wait_end(to);
        checks++; if (err8 !== 1'b1 || done8 !== 1'b0) begin failures++; $display("FAIL len0_err got=%0b%0b exp=10", err8, done8); end
        checks++; if (hold8 !== 1'b1) begin failures++; $display("FAIL len0_hold got=%0b exp=1", hold8); end
        checks++; if (nw8 !== 0 || wl8 !== 9'd0) begin failures++; $display("FAIL len0_writes got=%0d/%0d exp=0/0", nw8, wl8); end
        pulse_start();
        send_image(16'd257, 1'b0, 1'b0);
        wait_end(to);
        checks++; if (err8 !== 1'b1 || nw8 !== 0) begin failures++; $display("FAIL len257_err got=%0b/%0d exp=1/0", err8, nw8); end
        rand_img(1);
        pulse_start();
        checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL err_clear got=%0b exp=0", err8); end
        send_image(16'd1, 1'b0, 1'b0);
        wait_end(to);
        checks++; if (err8 !== 1'b0 || done8 !== 1'b1) begin failures++; $display("FAIL recover_done got=%0b%0b exp=01", err8, done8); end
        checks++; if (mem8[0] !== img[0] || nw8 !== 1) begin failures++; $display("FAIL recover_w0 got=%08h/%0d exp=%08h/1", mem8[0], nw8, img[0]); end
    endtask

    task automatic test_small_depth();
        bit to;
        sel = 1'b1;
        clear_mon();
        img = {};
        pulse_start();
        send_image(16'd5, 1'b0, 1'b0);
        wait_end(to);
        checks++; if (err2 !== 1'b1 || nw2 !== 0) begin failures++; $display("FAIL small_len5 got=%0b/%0d exp=1/0", err2, nw2); end
        rand_img(4);
        pulse_start();
        send_image(16'd4, 1'b0, 1'b0);
        wait_end(to);
        checks++; if (done2 !== 1'b1 || to) begin failures++; $display("FAIL small_done got=%0b exp=1", done2); end
        checks++; if (nw2 !== 4 || wl2 !== 3'd4) begin failures++; $display("FAIL small_count got=%0d/%0d exp=4/4", nw2, wl2); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem2[i] !== img[i]) begin failures++; $display("FAIL small_w%0d got=%08h exp=%08h", i, mem2[i], img[i]); end
        end
        sel = 1'b0;
    endtask

    task automatic test_full_depth();
        bit to;
        int bad;
        sel = 1'b0;
        clear_mon();
        rand_img(256);
        pulse_start();
        send_image(16'd256, 1'b0, 1'b0);
        wait_end(to);
        checks++; if (done8 !== 1'b1 || to) begin failures++; $display("FAIL full_done got=%0b exp=1", done8); end
        checks++; if (nw8 !== 256 || wl8 !== 9'd256) begin failures++; $display("FAIL full_count got=%0d/%0d exp=256/256", nw8, wl8); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem8[i] !== img[i]) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL full_image got=%0d bad words exp=0", bad); end
    endtask

    task automatic test_stall_start();
        bit to;
        int n;
        int bad;
        sel = 1'b0;
        for (int pass = 0; pass < 3; pass++) begin
            n = $urandom_range(3, 8);
            rand_img(n);
            for (int g = 0; g < 2; g++) begin
                clear_mon();
                pulse_start();
                send_image(16'(n), g == 1, g == 1);
                wait_end(to);
                checks++; if (done8 !== 1'b1 || to) begin failures++; $display("FAIL stall_done pass=%0d gaps=%0d got=%0b exp=1", pass, g, done8); end
                checks++; if (nw8 !== n || wl8 !== 9'(n)) begin failures++; $display("FAIL stall_count pass=%0d gaps=%0d got=%0d/%0d exp=%0d", pass, g, nw8, wl8, n); end
                bad = 0;
                for (int i = 0; i < n; i++) if (mem8[i] !== img[i]) bad++;
                checks++; if (bad !== 0) begin failures++; $display("FAIL stall_image pass=%0d gaps=%0d got=%0d bad exp=0", pass, g, bad); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [31:0] w;
        sel = 1'b0;
        clear_mon();
        rand_img(2);
        pulse_start();
        send(8'd2, 1'b0, 1'b0);
        send(8'd0, 1'b0, 1'b0);
        w = img[0];
        for (int k = 0; k < 4; k++) send(w[8*k +: 8], 1'b0, 1'b0);
        w = img[1];
        for (int k = 0; k < 2; k++) send(w[8*k +: 8], 1'b0, 1'b0);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (rdy8 !== 1'b0 || we8 !== 1'b0 || hold8 !== 1'b1) begin failures++; $display("FAIL midrst_ctrl got=%0b%0b%0b exp=001", rdy8, we8, hold8); end
        checks++; if (addr8 !== 8'd0 || wd8 !== 32'd0 || wl8 !== 9'd0) begin failures++; $display("FAIL midrst_data got=%0h/%08h/%0d exp=0/0/0", addr8, wd8, wl8); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (rdy8 !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%0b exp=0", rdy8); end
        checks++; if (nw8 !== 1 || mem8[0] !== img[0]) begin failures++; $display("FAIL midrst_writes got=%0d/%08h exp=1/%08h", nw8, mem8[0], img[0]); end
        clear_mon();
        rand_img(3);
        pulse_start();
        send_image(16'd3, 1'b1, 1'b0);
        wait_end(to);
        checks++; if (done8 !== 1'b1 || nw8 !== 3) begin failures++; $display("FAIL midrst_reload got=%0b/%0d exp=1/3", done8, nw8); end
        checks++; if (mem8[2] !== img[2]) begin failures++; $display("FAIL midrst_w2 got=%08h exp=%08h", mem8[2], img[2]); end
    endtask

    task automatic test_reload();
        bit to;
        sel = 1'b0;
        clear_mon();
        img = {32'hDEAD_BEEF};
        pulse_start();
        checks++; if (hold8 !== 1'b1 || done8 !== 1'b0 || wl8 !== 9'd0) begin failures++; $display("FAIL reload_start got=%0b%0b/%0d exp=10/0", hold8, done8, wl8); end
        send_image(16'd1, 1'b0, 1'b0);
        checks++; if (hold8 !== 1'b1) begin failures++; $display("FAIL reload_hold got=%0b exp=1", hold8); end
        wait_end(to);
        checks++; if (mem8[0] !== 32'hDEAD_BEEF || nw8 !== 1) begin failures++; $display("FAIL reload_w0 got=%08h/%0d exp=deadbeef/1", mem8[0], nw8); end
        checks++; if (done8 !== 1'b1 || hold8 !== 1'b0) begin failures++; $display("FAIL reload_done got=%0b%0b exp=10", done8, hold8); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        data  = 8'd0;
        sel   = 1'b0;
        inv   = 0;
        cyc   = 0;
        pd8   = 1'b0;
        clear_mon();
        test_reset();
        test_basic();
        test_len_err();
        test_small_depth();
        test_full_depth();
        test_stall_start();
        test_reset_mid();
        test_reload();
        checks++; if (inv !== 0) begin failures++; $display("FAIL hold_invariant got=%0d violations exp=0", inv); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a program load.
REQ-005 byte_valid  input  1  loader byte stream: byte_data holds a valid byte.
REQ-006 byte_data  input  8  loader byte stream payload.
REQ-007 byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 imem_wdata  output  32  instruction word to write.
REQ-011 cpu_hold  output  1  holds the pipeline (PC and fetch) in reset while high.
REQ-012 done  output  1  load completed successfully.
REQ-013 error  output  1  load rejected (bad length).
REQ-014 words_loaded  output  ADDR_W+1  count of words written in the current or last load.

Function
REQ-015 The block SHALL be the writer of the instruction memory read by the fetch stage; it is the only writer.
REQ-016 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both high; byte_data is ignored otherwise.
REQ-017 States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-018 IDLE: byte_ready=0, cpu_hold=1; start -> LEN_LO.
REQ-019 LEN_LO: byte_ready=1; transfer stores len[7:0] -> LEN_HI.
REQ-020 LEN_HI: byte_ready=1; transfer stores len[15:8]; if len==0 or len>DEPTH -> ERR, else -> DATA with word address 0, lane 0.
REQ-021 DATA: byte_ready=1; transfer k (lane 0..3) loads imem_wdata[8k+7:8k] (little-endian); transfer on lane 3 -> WRITE.
REQ-022 WRITE: exactly one cycle; imem_we=1, byte_ready=0, imem_addr=current word address, imem_wdata=assembled word; words_loaded increments at the end of the cycle.
REQ-023 After WRITE: if words_loaded (post-increment) == len -> DONE, else word address +1, lane 0 -> DATA.
REQ-024 Write latency: imem_we high in the cycle immediately after the lane-3 transfer; no write is issued for a partial word.
REQ-025 DONE: done=1, cpu_hold=0, byte_ready=0; done is registered and first high the cycle after the final WRITE.
REQ-026 ERR: error=1, cpu_hold=1, byte_ready=0, no memory writes.
REQ-027 start SHALL be honoured only in IDLE, DONE and ERR; in DONE/ERR it clears done/error, sets cpu_hold=1, clears words_loaded, -> LEN_LO, all in the same edge.
REQ-028 start during LEN_LO, LEN_HI, DATA, WRITE SHALL be ignored.
REQ-029 A stalled stream (byte_valid low) SHALL hold state, lane, address and partial word indefinitely.
REQ-030 imem_we SHALL be 0 in every state except WRITE; imem_addr never exceeds DEPTH-1.
REQ-031 len==DEPTH SHALL be accepted and fill address 0..DEPTH-1 with no wrap.
REQ-032 cpu_hold SHALL be low only in DONE.

Reset
REQ-033 reset high at an edge SHALL force IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, len=0, lane=0, regardless of state.
REQ-034 reset mid-load SHALL abandon the partial word; no write is issued for it; reset has priority over start.

Verification
REQ-035 reset, start, bytes 02 00 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0 and 0x00100093 @1, one imem_we each, done=1 and cpu_hold=0 one cycle after second write, words_loaded=2.
REQ-036 Length 00 00 -> error=1, no imem_we, cpu_hold=1; then start, valid 1-word load -> error=0, done=1.
REQ-037 ADDR_W=2, length 05 00 -> ERR; length 04 00 plus 16 bytes -> addresses 0..3 written, done=1.
REQ-038 byte_valid toggled randomly mid-word, start pulsed during DATA -> identical memory image to back-to-back stream, start ignored.
REQ-039 reset asserted after 2 bytes of word 1 -> IDLE outputs per REQ-033, no write of word 1; fresh load afterwards succeeds.
REQ-040 After DONE, start and new 1-word image 0xDEADBEEF -> cpu_hold=1 during load, @0 = 0xDEADBEEF, done re-asserts.
